// File: rtl/life_gen_sequencer.sv
// rtl/life_gen_sequencer.sv - seed load, generation update and serial drain sequencer for the 64-cell Life array
// Optional generation limit (gen_limit / limit_hit) is built when LIFE_GEN_LIMIT_EN is defined.
module life_gen_sequencer #(
    parameter int N_CELLS  = 64,
    parameter int GEN_W    = 16,
    parameter int PERIOD_W = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                cmd_load,
    input  logic                cmd_step,
    input  logic                cmd_run,
    input  logic                cmd_pause,
    input  logic [PERIOD_W-1:0] run_period,
    input  logic                load_bit,
    input  logic                load_valid,
    output logic                load_ready,
    output logic                array_shift,
    output logic                array_recirc,
    output logic                array_in,
    output logic                array_update,
    input  logic                array_out,
    output logic                out_bit,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_last,
    output logic [GEN_W-1:0]    gen_count,
    output logic                busy,
    output logic                running
`ifdef LIFE_GEN_LIMIT_EN
    ,
    input  logic [GEN_W-1:0]    gen_limit,
    output logic                limit_hit
`endif
);

    localparam int BEAT_W = (N_CELLS > 1) ? $clog2(N_CELLS) : 1;
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(N_CELLS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_UPDATE,
        S_DRAIN,
        S_WAIT
    } state_t;

    state_t              state_q, state_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [GEN_W-1:0]    gen_count_q, gen_count_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [PERIOD_W-1:0] wait_q, wait_d;
    logic                running_q, running_d;
    logic                load_ready_q, load_ready_d;
    logic                out_valid_q, out_valid_d;
    logic                recirc_q, recirc_d;
    logic                update_q, update_d;
    logic                last_q, last_d;
    logic                busy_q, busy_d;
    logic                limit_hit_q, limit_hit_d;
    logic                load_acc;
    logic                out_acc;
    logic                keep_running;

    assign load_acc = load_ready_q & load_valid;
    assign out_acc  = out_valid_q & out_ready;

    // Handshake-qualified strobes stay combinational so a beat moves in the cycle it is accepted.
    assign array_shift  = load_acc | out_acc;
    assign array_in     = load_ready_q & load_bit;
    assign array_recirc = recirc_q;
    assign array_update = update_q;
    assign out_bit      = out_valid_q & array_out;
    assign out_valid    = out_valid_q;
    assign out_last     = last_q;
    assign load_ready   = load_ready_q;
    assign gen_count    = gen_count_q;
    assign busy         = busy_q;
    assign running      = running_q;

    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        gen_count_d  = gen_count_q;
        period_d     = period_q;
        wait_d       = wait_q;
        running_d    = running_q;
        limit_hit_d  = 1'b0;
        keep_running = 1'b0;

        if (cmd_pause) begin
            running_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (cmd_pause) begin
                    state_d = S_IDLE;
                end else if (cmd_load) begin
                    state_d     = S_LOAD;
                    beat_d      = '0;
                    gen_count_d = '0;
                end else if (cmd_step) begin
                    state_d = S_UPDATE;
                end else if (cmd_run) begin
                    state_d   = S_UPDATE;
                    running_d = 1'b1;
                    period_d  = run_period;
                end
            end
            S_LOAD: begin
                if (load_acc) begin
                    beat_d = beat_q + BEAT_W'(1);
                    if (beat_q == BEAT_LAST) begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_UPDATE: begin
                gen_count_d = gen_count_q + GEN_W'(1);
                beat_d      = '0;
                state_d     = S_DRAIN;
            end
            S_DRAIN: begin
                if (out_acc) begin
                    beat_d = beat_q + BEAT_W'(1);
                    if (beat_q == BEAT_LAST) begin
                        keep_running = running_d;
`ifdef LIFE_GEN_LIMIT_EN
                        if (running_d && (gen_limit != '0) && (gen_count_q == gen_limit)) begin
                            keep_running = 1'b0;
                            running_d    = 1'b0;
                            limit_hit_d  = 1'b1;
                        end
`endif
                        if (!keep_running) begin
                            state_d = S_IDLE;
                        end else if (period_q == '0) begin
                            state_d = S_UPDATE;
                        end else begin
                            state_d = S_WAIT;
                            wait_d  = period_q;
                        end
                    end
                end
            end
            S_WAIT: begin
                if (cmd_pause) begin
                    state_d = S_IDLE;
                end else if (wait_q == '0) begin
                    state_d = S_UPDATE;
                end else begin
                    wait_d = wait_q - PERIOD_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they come straight off flops.
        load_ready_d = (state_d == S_LOAD);
        out_valid_d  = (state_d == S_DRAIN);
        recirc_d     = (state_d == S_DRAIN);
        update_d     = (state_d == S_UPDATE);
        last_d       = (state_d == S_DRAIN) && (beat_d == BEAT_LAST);
        busy_d       = (state_d != S_IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            beat_q       <= '0;
            gen_count_q  <= '0;
            period_q     <= '0;
            wait_q       <= '0;
            running_q    <= 1'b0;
            load_ready_q <= 1'b0;
            out_valid_q  <= 1'b0;
            recirc_q     <= 1'b0;
            update_q     <= 1'b0;
            last_q       <= 1'b0;
            busy_q       <= 1'b0;
            limit_hit_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            gen_count_q  <= gen_count_d;
            period_q     <= period_d;
            wait_q       <= wait_d;
            running_q    <= running_d;
            load_ready_q <= load_ready_d;
            out_valid_q  <= out_valid_d;
            recirc_q     <= recirc_d;
            update_q     <= update_d;
            last_q       <= last_d;
            busy_q       <= busy_d;
            limit_hit_q  <= limit_hit_d;
        end
    end

`ifdef LIFE_GEN_LIMIT_EN
    assign limit_hit = limit_hit_q;
`else
    logic unused_limit;
    assign unused_limit = limit_hit_q;
`endif

endmodule
